// File: rtl/xor_pkg.sv
// xor_pack shared types and widths.
// Imported by the packer, its assembly stage and its interface.
package xor_pkg;

   localparam int BYTE_W    = 8;
   localparam int MAX_BYTES = 8;
   localparam int LEN_W     = 4;

   typedef enum logic [1:0] {
      IDLE,
      FILL,
      FULL,
      DRAIN
   } state_e;

endpackage

// File: rtl/xor_pack_if.sv
// Byte-in / word-out handshake bundle for xor_pack.
// slave is the packer's view, master is the driver's view.
interface xor_pack_if
   import xor_pkg::*;
#(
   parameter int BYTES = 4
);

   logic                    in_valid;
   logic [BYTE_W-1:0]       in_data;
   logic                    in_ready;
   logic                    flush;
   logic                    out_valid;
   logic [BYTE_W*BYTES-1:0] out_data;
   logic [LEN_W-1:0]        out_len;
   logic [BYTE_W-1:0]       out_parity;
   logic                    out_ready;

   modport slave (
      input  in_valid,
      input  in_data,
      input  flush,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out_data,
      output out_len,
      output out_parity
   );

   modport master (
      output in_valid,
      output in_data,
      output flush,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out_data,
      input  out_len,
      input  out_parity
   );

endinterface

// File: rtl/xor_pack_asm.sv
// Assembly register: byte lanes, fill count and running parity.
// A clear restarts the word; a write in the same cycle lands in lane 0.
module xor_pack_asm
   import xor_pkg::*;
#(
   parameter int BYTES = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    i_wr,
   input  logic [BYTE_W-1:0]       i_data,
   input  logic                    i_clr,
   output logic [BYTE_W*BYTES-1:0] o_lanes,
   output logic [LEN_W-1:0]        o_count,
   output logic [BYTE_W-1:0]       o_parity
);

   localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

   logic [BYTE_W-1:0] r_lane [BYTES];
   logic [LEN_W-1:0]  r_count;
   logic [BYTE_W-1:0] r_parity;
   logic [LEN_W-1:0]  w_idx;

   assign w_idx = i_clr ? '0 : r_count;

   // Lanes are zeroed on clear so unused lanes of a partial word read 0.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < BYTES; i++) begin
            r_lane[i] <= '0;
         end
         r_count  <= '0;
         r_parity <= '0;
      end else begin
         for (int i = 0; i < BYTES; i++) begin
            if (i_wr && (w_idx == LEN_W'(i))) begin
               r_lane[i] <= i_data;
            end else if (i_clr) begin
               r_lane[i] <= '0;
            end
         end
         if (i_clr) begin
            r_count  <= i_wr ? ONE : '0;
            r_parity <= i_wr ? i_data : '0;
         end else if (i_wr) begin
            r_count  <= r_count + ONE;
            r_parity <= r_parity ^ i_data;
         end
      end
   end

   always_comb begin
      o_lanes = '0;
      for (int i = 0; i < BYTES; i++) begin
         o_lanes[i*BYTE_W +: BYTE_W] = r_lane[i];
      end
   end

   assign o_count  = r_count;
   assign o_parity = r_parity;

endmodule

// File: rtl/xor_pack.sv
// Packs ciphertext bytes into BYTES-wide words with parity and length.
// Holds the output slot, handshakes and flush control.
module xor_pack
   import xor_pkg::*;
#(
   parameter int BYTES = 4
) (
   input  logic       clk,
   input  logic       rst,
   xor_pack_if.slave  bus
);

   localparam logic [LEN_W-1:0] FULL_CNT = LEN_W'(BYTES);
   localparam logic [LEN_W-1:0] ONE      = LEN_W'(1);

   logic [BYTE_W*BYTES-1:0] w_lanes;
   logic [LEN_W-1:0]        w_count;
   logic [BYTE_W-1:0]       w_parity;
   state_e                  w_state;
   logic                    w_out_free;
   logic                    w_xfer;
   logic                    w_in_ready;
   logic                    w_accept;
   logic [LEN_W-1:0]        w_cnt_after;

   logic                    r_flush_pend;
   logic                    r_out_valid;
   logic [BYTE_W*BYTES-1:0] r_out_data;
   logic [LEN_W-1:0]        r_out_len;
   logic [BYTE_W-1:0]       r_out_parity;

   always_comb begin
      w_state = IDLE;
      if (r_flush_pend && (w_count != '0)) begin
         w_state = DRAIN;
      end else if (w_count == FULL_CNT) begin
         w_state = FULL;
      end else if (w_count != '0) begin
         w_state = FILL;
      end
   end

   assign w_out_free = !r_out_valid || bus.out_ready;
   assign w_xfer     = ((w_state == FULL) || (w_state == DRAIN))
                       && w_out_free;

   // A full word can take a byte in the cycle it leaves for the slot.
   assign w_in_ready = rst && !r_flush_pend
                       && ((w_count < FULL_CNT)
                           || ((w_state == FULL) && w_out_free));
   assign w_accept   = bus.in_valid && w_in_ready;

   always_comb begin
      w_cnt_after = w_count + (w_accept ? ONE : '0);
      if (w_xfer) begin
         w_cnt_after = w_accept ? ONE : '0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_flush_pend <= 1'b0;
      end else begin
         r_flush_pend <= (r_flush_pend && !w_xfer)
                         || (bus.flush && (w_cnt_after != '0));
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_out_valid  <= 1'b0;
         r_out_data   <= '0;
         r_out_len    <= '0;
         r_out_parity <= '0;
      end else if (w_xfer) begin
         r_out_valid  <= 1'b1;
         r_out_data   <= w_lanes;
         r_out_len    <= w_count;
         r_out_parity <= w_parity;
      end else if (bus.out_ready) begin
         r_out_valid  <= 1'b0;
      end
   end

   xor_pack_asm #(
      .BYTES (BYTES)
   ) u_asm (
      .clk      (clk),
      .rst      (rst),
      .i_wr     (w_accept),
      .i_data   (bus.in_data),
      .i_clr    (w_xfer),
      .o_lanes  (w_lanes),
      .o_count  (w_count),
      .o_parity (w_parity)
   );

   assign bus.in_ready   = w_in_ready;
   assign bus.out_valid  = r_out_valid;
   assign bus.out_data   = r_out_data;
   assign bus.out_len    = r_out_len;
   assign bus.out_parity = r_out_parity;

endmodule

// File: doc/xor_pack.md
# xor_pack

Downstream stage for the `xor_gen` ciphertext path. It accepts one 8-bit ciphertext byte per handshake and packs BYTES consecutive bytes into one output word. Each word carries a running XOR parity byte and a valid-length field. A flush input emits a partial word at end of message, so the next stage (bus writer or FIFO) sees whole words with valid/ready backpressure.

## Interface
- BYTES, 4, bytes per output word; legal range 2..8
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  ciphertext byte present
- in_data  in  8  ciphertext byte (xor_gen `ciphertext`)
- in_ready  out  1  byte accepted when in_valid && in_ready
- flush  in  1  single-cycle request to emit current partial word
- out_valid  out  1  word present
- out_data  out  8*BYTES  packed word; first accepted byte in bits [7:0]
- out_len  out  4  number of valid bytes in out_data (1..BYTES)
- out_parity  out  8  XOR of all valid bytes in the word
- out_ready  in  1  word consumed when out_valid && out_ready

## Operation
- Two registers: assembly (lanes, count 0..BYTES, parity, flush_pending) and output slot (out_* registers).
- States from count/flush_pending: IDLE (count 0), FILL (0<count<BYTES), FULL (count==BYTES), DRAIN (flush_pending, count>0).
- out_free = !out_valid || out_ready.
- Transfer: when (FULL or DRAIN) && out_free, the assembly word moves to the output slot.
  - On transfer: count is set to 0, parity to 0, and flush_pending is cleared.
  - Unused lanes are zero. out_len = count.
- Accept: in_ready = (count<BYTES && !flush_pending) || (FULL && out_free && !flush_pending).
  - An accepted byte is written to lane[count] and XORed into parity; count increments.
  - If accepted in the same cycle as a transfer, the byte goes to lane 0 of the new word with parity = byte and count = 1.
- Flush:
  - flush with count>0 (after this cycle's accept) sets flush_pending.
  - flush with count==0 and no accept that cycle is ignored; no empty words are emitted.
  - A byte accepted in the flush cycle is included in the flushed word.
- Output slot is cleared (out_valid=0) on out_ready unless refilled in the same cycle.
- out_data, out_len and out_parity are held stable while out_valid && !out_ready.

## Timing
- Reset values, in effect while rst=0:
  - out_valid=0, out_data=0, out_len=0, out_parity=0
  - count=0, flush_pending=0
  - in_ready=0
- First cycle after reset release: in_ready=1.
- Latency:
  - Final byte of a word accepted at edge N, output free → out_valid=1 after edge N+1.
  - flush at edge N → partial word valid after edge N+1.
- Throughput: 1 byte/cycle sustained while out_ready=1; no bubbles at word boundaries.
- Backpressure:
  - With output held, the assembly still fills up to BYTES bytes.
  - in_ready then drops until out_ready.
  - Worst-case buffering is 2*BYTES bytes.
- Reset mid-operation drops partial and held words; no residue appears after release.
- flush asserted while flush_pending is already set is ignored.

## Structure
- Shared package `xor_pkg`:
  - BYTE_W=8, MAX_BYTES=8, LEN_W=4
  - state enum {IDLE, FILL, FULL, DRAIN} for debug/assertions
- Sub-module `xor_pack_asm` holds lane register, count and parity (write-at-index, clear-on-transfer).
- The top level holds the output slot, handshake logic and flush control.
- Estimated size: ~200 lines RTL.

## Test plan
- Basic word:
  - Bytes 0x11,0x22,0x33,0x44 with out_ready=1 → one word, out_data=0x44332211, out_len=4, out_parity=0x44.
  - out_valid rises one cycle after the 0x44 accept.
- Partial flush: bytes 0xA5,0x5A, then flush → out_data=0x00005AA5, out_len=2, out_parity=0xFF.
- Empty flush: flush with no pending bytes → out_valid stays 0 for 10 cycles.
- Backpressure:
  - out_ready=0, stream 9 bytes 0x01..0x09 → in_ready low while 0x09 is presented.
  - Raise out_ready → words 0x04030201 then 0x08070605 in order, then 0x09 accepted.
- Back-to-back: 8 bytes on consecutive cycles with out_ready=1 → in_ready never drops; two words exactly 4 cycles apart.
- Reset mid-word:
  - 0xDE,0xAD accepted, rst pulsed low, then 0x01..0x04 → sole output 0x04030201, parity 0x04.
  - All outputs read 0 while in reset.
